// File: rtl/input_repeat_buffer.sv
// Captures BUFFER_SIZE input beats, then replays the captured block REPEAT times.
// State | meaning: S_FILL | accepting input beats into storage; S_PLAY | replaying storage, input blocked.
module input_repeat_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_NUM      = 1,
  parameter int REPEAT      = 2,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [IN_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  localparam int CW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BUFFER_SIZE - 1);
  localparam logic [RW-1:0] LAST_REP  = RW'(REPEAT - 1);

  typedef enum logic {S_FILL, S_PLAY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic [RW-1:0]         r_rep_cnt;
  logic [DATA_WIDTH-1:0] r_mem [BUFFER_SIZE-1:0][IN_NUM-1:0];
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_rd_last;
  logic                  w_rep_last;

  assign w_in_hs    = data_in_valid & data_in_ready;
  assign w_out_hs   = data_out_valid & data_out_ready;
  assign w_rd_last  = (r_rd_cnt == LAST_BEAT);
  assign w_rep_last = (r_rep_cnt == LAST_REP);

  // Ready/valid come only from the state register, so neither side sees the other combinationally.
  always_comb begin
    w_state_nxt    = r_state;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    case (r_state)
      S_FILL: begin
        data_in_ready = 1'b1;
        if (data_in_valid && (r_wr_cnt == LAST_BEAT))
          w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        data_out_valid = 1'b1;
        if (data_out_ready && w_rd_last && w_rep_last)
          w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FILL;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_hs)
        r_wr_cnt <= (r_wr_cnt == LAST_BEAT) ? '0 : r_wr_cnt + CW'(1);
      if (w_out_hs) begin
        if (w_rd_last) begin
          r_rd_cnt  <= '0;
          r_rep_cnt <= w_rep_last ? '0 : r_rep_cnt + RW'(1);
        end else begin
          r_rd_cnt <= r_rd_cnt + CW'(1);
        end
      end
    end
  end

  // Storage needs no reset; contents are only read after a full block is written.
  always_ff @(posedge clk) begin
    if (w_in_hs)
      r_mem[r_wr_cnt] <= data_in;
  end

  assign data_out = r_mem[r_rd_cnt];

endmodule

// File: tb/tb_input_repeat_buffer.sv
// Scoreboard bench: accepted input beats form blocks that are queued REPEAT times and popped on output handshakes.
module tb_input_repeat_buffer;
  localparam int DW  = 8;
  localparam int IN  = 2;
  localparam int BS  = 3;
  localparam int REP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] data_in  [IN-1:0];
  logic [DW-1:0] data_out [IN-1:0];
  logic data_in_valid, data_in_ready, data_out_valid;
  logic data_out_ready = 1'b1;

  logic [DW-1:0] e_in  [0:0];
  logic [DW-1:0] e_out [0:0];
  logic e_in_valid, e_in_ready, e_out_valid;
  logic e_out_ready = 1'b1;

  input_repeat_buffer #(.DATA_WIDTH(DW), .IN_NUM(IN), .REPEAT(REP), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  input_repeat_buffer #(.DATA_WIDTH(DW), .IN_NUM(1), .REPEAT(3), .BUFFER_SIZE(1)) dut_edge (
    .clk(clk), .rst(rst),
    .data_in(e_in), .data_in_valid(e_in_valid), .data_in_ready(e_in_ready),
    .data_out(e_out), .data_out_valid(e_out_valid), .data_out_ready(e_out_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [DW-1:0] d [IN-1:0]);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < IN; i++) p[i*DW +: DW] = d[i];
    return p;
  endfunction

  // Reference model and scoreboard
  logic [31:0] q[$];
  logic [31:0] blk [BS];
  bit          m_play = 1'b0;
  int          m_fill = 0;
  int          m_outs = 0;
  int          out_hs = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  bit          bp_en = 1'b0;

  always @(posedge clk) begin
    #1;
    data_out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_play = 1'b0;
      m_fill = 0;
      m_outs = 0;
      prev_stall = 1'b0;
    end else begin
      check_eq("in_ready", {31'b0, data_in_ready}, {31'b0, !m_play});
      check_eq("out_valid", {31'b0, data_out_valid}, {31'b0, m_play});
      if (prev_stall) check_eq("stall_hold", pack(data_out), prev_data);
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = pack(data_out);
      if (data_in_valid && data_in_ready) begin
        blk[m_fill] = pack(data_in);
        m_fill++;
        if (m_fill == BS) begin
          for (int r = 0; r < REP; r++)
            for (int b = 0; b < BS; b++) q.push_back(blk[b]);
          m_fill = 0;
          m_play = 1'b1;
        end
      end
      if (data_out_valid && data_out_ready) begin
        out_hs++;
        if (q.size() == 0) check_eq("unexpected_out", 32'd1, 32'd0);
        else check_eq("out_data", pack(data_out), q.pop_front());
        m_outs++;
        if (m_outs == BS * REP) begin
          m_outs = 0;
          m_play = 1'b0;
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
    logic hs;
    bit ok;
    ok = 1'b0;
    data_in[0] = a;
    data_in[1] = b;
    data_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hs = data_in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("in_timeout", 32'd0, 32'd1);
    data_in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_play) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("drain", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int first, input int gap);
    for (int k = 0; k < BS; k++) send(DW'(first + 2*k), DW'(first + 2*k + 1), gap);
  endtask

  int base;

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in = '{8'd0, 8'd0};
    e_in_valid = 1'b0;
    e_in[0] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_in_ready", {31'b0, data_in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'b0, data_out_valid}, 32'd0);

    base = out_hs;
    send_block(1, 0);
    wait_idle();
    check_eq("basic_beats", out_hs - base, BS * REP);

    base = out_hs;
    send_block(1, 2);
    wait_idle();
    check_eq("gap_beats", out_hs - base, BS * REP);

    bp_en = 1'b1;
    base = out_hs;
    send_block(21, 1);
    wait_idle();
    check_eq("bp_beats", out_hs - base, BS * REP);
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    base = out_hs;
    send_block(1, 0);
    send_block(7, 0);
    wait_idle();
    check_eq("b2b_beats", out_hs - base, 2 * BS * REP);

    base = out_hs;
    send_block(40, 0);
    for (int i = 0; i < 50; i++) begin
      if (out_hs >= base + 2) break;
      @(posedge clk);
      #1;
    end
    check_eq("pre_rst_beats", out_hs - base, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_out_valid", {31'b0, data_out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'b0, data_in_ready}, 32'd1);
    base = out_hs;
    send_block(10, 0);
    wait_idle();
    check_eq("post_rst_beats", out_hs - base, BS * REP);

    e_in[0] = 8'hAA;
    e_in_valid = 1'b1;
    @(negedge clk);
    check_eq("edge_fill_ready", {31'b0, e_in_ready}, 32'd1);
    check_eq("edge_fill_valid", {31'b0, e_out_valid}, 32'd0);
    @(posedge clk);
    #1;
    e_in[0] = 8'hBB;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("edge_valid", {31'b0, e_out_valid}, 32'd1);
      check_eq("edge_data", {24'b0, e_out[0]}, 32'hAA);
      check_eq("edge_in_block", {31'b0, e_in_ready}, 32'd0);
    end
    @(negedge clk);
    check_eq("edge_refill_ready", {31'b0, e_in_ready}, 32'd1);
    check_eq("edge_refill_valid", {31'b0, e_out_valid}, 32'd0);
    @(posedge clk);
    #1;
    e_in_valid = 1'b0;
    @(negedge clk);
    check_eq("edge_next_valid", {31'b0, e_out_valid}, 32'd1);
    check_eq("edge_next_data", {24'b0, e_out[0]}, 32'hBB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
